// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Programmable wait states precede the one-cycle array access.
module mem_responder #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  input  logic [WORD_SIZE/8-1:0] req_be,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_SIZE-1:0]   resp_rdata,
  output logic                   resp_write,
  output logic [15:0]            txn_count
);

  localparam int NB = WORD_SIZE / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, state_n;

  logic [WORD_SIZE-1:0]  mem [DEPTH];
  logic [3:0]            cnt;
  logic                  cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [WORD_SIZE-1:0]  cap_wdata;
  logic [NB-1:0]         cap_be;
  logic [WORD_SIZE-1:0]  rd_word;
  logic [WORD_SIZE-1:0]  merged;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic                  write_q;
  logic [15:0]           txn_q;
  logic [15:0]           txn_d;
  logic                  accept;
  logic                  done;
  logic                  do_wr;

  assign accept = req_valid & req_ready;
  assign done   = resp_valid & resp_ready;
  assign do_wr  = (state == S_ACCESS) & cap_write;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:
        if (cnt == 4'd0) state_n = S_ACCESS;
      S_ACCESS:
        state_n = S_RESP;
      S_RESP:
        if (resp_ready) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  assign rd_word = mem[cap_addr];

  // Disabled bytes keep the old array contents.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++)
      if (cap_be[i]) merged[8*i +: 8] = cap_wdata[8*i +: 8];
  end

  assign txn_d = (done && txn_q != 16'hFFFF) ? txn_q + 16'd1 : txn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      txn_q     <= 16'd0;
    end else begin
      txn_q <= txn_d;
      if (accept) begin
        cnt       <= WLOAD;
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_ACCESS) begin
        rdata_q <= cap_write ? merged : rd_word;
        write_q <= cap_write;
      end
    end
  end

  // Array is never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[cap_addr] <= merged;
  end

  assign resp_rdata = rdata_q;
  assign resp_write = write_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, stall/reset/saturation sequences,
// and random transactions against a word-array reference model.
module tb_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_write;
  logic [31:0] resp_rdata;
  logic [15:0] txn_count;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [7:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_resp_valid, z_resp_ready, z_resp_write;
  logic [31:0] z_resp_rdata;
  logic [15:0] z_txn_count;

  mem_responder #(
    .WORD_SIZE(32), .ADDR_WIDTH(8), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_write(resp_write),
    .txn_count(txn_count)
  );

  mem_responder #(
    .WORD_SIZE(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_write(z_resp_write),
    .txn_count(z_txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [7:0]  addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit [31:0] exp;
  } vec_t;

  int vectors;
  int miscompares;
  bit [31:0] mm [256];
  bit [15:0] model_cnt;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic bit [31:0] mergew(input bit [31:0] old,
                                       input bit [31:0] wd,
                                       input bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic txn(input bit wr, input bit [7:0] a,
                     input bit [31:0] wd, input bit [3:0] be,
                     input int hold, input bit [31:0] exp);
    int lat;
    bit [31:0] held;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = wd;
    req_be     = be;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = ~wr;
    req_addr  = ~a;
    req_wdata = ~wd;
    req_be    = ~be;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!resp_valid && lat < 20);
    chk("latency", lat, W + 1);
    chk("rdata", resp_rdata, exp);
    chk("resp_write", resp_write, wr);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1;
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_rdata", resp_rdata, held);
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    if (model_cnt != 16'hFFFF) model_cnt++;
    if (wr) mm[a] = mergew(mm[a], wd, be);
    chk("resp_done", resp_valid, 0);
    chk("back_to_idle", req_ready, 1);
    chk("txn_count", txn_count, model_cnt);
  endtask

  vec_t tbl[7];

  initial begin
    vectors = 0;
    miscompares = 0;
    model_cnt = 0;
    foreach (mm[i]) mm[i] = 0;
    clk = 0;
    rst = 1;
    req_valid = 0; req_write = 0; req_addr = 0;
    req_wdata = 0; req_be = 0; resp_ready = 1;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0;
    z_req_wdata = 0; z_req_be = 0; z_resp_ready = 1;

    tbl[0] = '{1, 8'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tbl[1] = '{1, 8'h10, 32'h11223344, 4'h5, 32'hDE22BE44};
    tbl[2] = '{0, 8'h10, 32'h0,        4'h0, 32'hDE22BE44};
    tbl[3] = '{1, 8'h11, 32'hCAFEF00D, 4'h0, 32'h00000000};
    tbl[4] = '{0, 8'h11, 32'h0,        4'h0, 32'h00000000};
    tbl[5] = '{1, 8'h11, 32'hAABBCCDD, 4'h8, 32'hAA000000};
    tbl[6] = '{0, 8'hFF, 32'h0,        4'h0, 32'h00000000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_resp_write", resp_write, 0);
    chk("rst_txn_count", txn_count, 0);

    foreach (tbl[i])
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0, tbl[i].exp);

    // Stalled read with a competing request pending.
    txn(0, 8'h10, 32'h0, 4'h0, 5, mm[8'h10]);

    // Reset lands on the ACCESS edge of a write.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 8'h20;
    req_wdata = 32'h12345678; req_be = 4'hF; resp_ready = 1;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_cnt = 0;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_txn_count", txn_count, 0);
    chk("abort_rdata", resp_rdata, 0);
    txn(0, 8'h20, 32'h0, 4'h0, 0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      bit wr;
      bit [7:0] a;
      bit [31:0] wd;
      bit [3:0] be;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      txn(wr, a, wd, be, $urandom_range(0, 2),
          wr ? mergew(mm[a], wd, be) : mm[a]);
    end

    // Zero-wait-state instance: unwritten read.
    @(negedge clk);
    z_req_valid = 1; z_req_addr = 8'h42; z_resp_ready = 1;
    @(posedge clk);
    #1 z_req_valid = 0;
    @(negedge clk);
    chk("w0_not_yet", z_resp_valid, 0);
    @(negedge clk);
    chk("w0_resp_valid", z_resp_valid, 1);
    chk("w0_rdata", z_resp_rdata, 0);
    @(negedge clk);
    chk("w0_txn_count", z_txn_count, 1);

    // Saturation from a preloaded counter.
    @(negedge clk);
    force dut.txn_q = 16'hFFFD;
    @(negedge clk);
    @(negedge clk);
    release dut.txn_q;
    model_cnt = 16'hFFFD;
    @(negedge clk);
    chk("preload", txn_count, 16'hFFFD);
    repeat (3) txn(0, 8'h10, 32'h0, 4'h0, 0, mm[8'h10]);
    chk("saturated", txn_count, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
